// File: rtl/pc_unit.sv
// Program-counter unit: holds the PC, selects the next PC (seq/branch/jump/reg/call/ret),
// keeps a circular return-address stack and redirects to the exception vector.
module pc_unit #(
    parameter int                WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR = WIDTH'('h80),
    parameter int                RAS_DEPTH  = 4,
    parameter int                INC        = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PCWre,
    input  logic [2:0]       PCSrc,
    input  logic [15:0]      Imm,
    input  logic [25:0]      JTarget,
    input  logic [WIDTH-1:0] RegTarget,
    input  logic             exc_req,
    output logic [WIDTH-1:0] PCOut,
    output logic [WIDTH-1:0] PCPlus4,
    output logic [WIDTH-1:0] EPC,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf,
    output logic             misalign
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'b000,
        SRC_BR   = 3'b001,
        SRC_J    = 3'b010,
        SRC_JR   = 3'b011,
        SRC_CALL = 3'b100,
        SRC_RET  = 3'b101
    } pcsrc_e;

    logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d;
    logic             push;

    logic [WIDTH-1:0] pc_plus, br_tgt, j_tgt, reg_tgt;

    assign pc_plus = pc_q + WIDTH'(INC);
    assign br_tgt  = pc_plus + {{(WIDTH-18){Imm[15]}}, Imm, 2'b00};
    assign j_tgt   = {pc_plus[WIDTH-1:28], JTarget, 2'b00};
    assign reg_tgt = {RegTarget[WIDTH-1:2], 2'b00};

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        top_d = top_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        mis_d = mis_q;
        push  = 1'b0;
        if (PCWre) begin
            if (exc_req) begin
                pc_d  = EXC_VECTOR;
                epc_d = pc_q;
            end else begin
                case (pcsrc_e'(PCSrc))
                    SRC_SEQ: pc_d = pc_plus;
                    SRC_BR:  pc_d = br_tgt;
                    SRC_J:   pc_d = j_tgt;
                    SRC_JR: begin
                        pc_d = reg_tgt;
                        if (RegTarget[1:0] != 2'b00) mis_d = 1'b1;
                    end
                    SRC_CALL: begin
                        // Wrapping the top pointer overwrites the oldest entry when full.
                        pc_d  = j_tgt;
                        push  = 1'b1;
                        top_d = top_q + PW'(1);
                        if (ras_full) ovf_d = 1'b1;
                        else          cnt_d = cnt_q + CW'(1);
                    end
                    SRC_RET: begin
                        if (ras_empty) begin
                            pc_d  = reg_tgt;
                            unf_d = 1'b1;
                        end else begin
                            pc_d  = ras_q[top_q];
                            top_d = top_q - PW'(1);
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    default: pc_d = pc_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q  <= RESET_ADDR;
            epc_q <= '0;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            mis_q <= mis_d;
        end
    end

    // Stack contents need no reset: count gates every read.
    always_ff @(posedge CLK) begin
        if (push) ras_q[top_d] <= pc_plus;
    end

    assign PCOut    = pc_q;
    assign PCPlus4  = pc_plus;
    assign EPC      = epc_q;
    assign ras_ovf  = ovf_q;
    assign ras_unf  = unf_q;
    assign misalign = mis_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit: table of {inputs, expected state} plus an async reset sequence.
module tb_pc_unit;
    logic        CLK = 1'b0;
    logic        RST;
    logic        PCWre;
    logic [2:0]  PCSrc;
    logic [15:0] Imm;
    logic [25:0] JTarget;
    logic [31:0] RegTarget;
    logic        exc_req;
    logic [31:0] PCOut, PCPlus4, EPC;
    logic        ras_empty, ras_full, ras_ovf, ras_unf, misalign;

    int checks = 0;
    int errors = 0;

    pc_unit dut (
        .CLK(CLK), .RST(RST), .PCWre(PCWre), .PCSrc(PCSrc), .Imm(Imm),
        .JTarget(JTarget), .RegTarget(RegTarget), .exc_req(exc_req),
        .PCOut(PCOut), .PCPlus4(PCPlus4), .EPC(EPC),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
        .ras_unf(ras_unf), .misalign(misalign)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [2:0]  src;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] rt;
        logic        exc;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [4:0]  fl;   // {empty, full, ovf, unf, misalign}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic we, input logic [2:0] src, input logic [15:0] imm,
                               input logic [25:0] jt, input logic [31:0] rt, input logic exc,
                               input logic [31:0] pc, input logic [31:0] epc, input logic [4:0] fl);
        vec_t r;
        r.we = we; r.src = src; r.imm = imm; r.jt = jt; r.rt = rt; r.exc = exc;
        r.pc = pc; r.epc = epc; r.fl = fl;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_state(input int idx, input logic [31:0] pc, input logic [31:0] epc,
                               input logic [4:0] fl);
        chk("PCOut", idx, PCOut, pc);
        chk("PCPlus4", idx, PCPlus4, pc + 32'd4);
        chk("EPC", idx, EPC, epc);
        chk("flags", idx, {27'd0, ras_empty, ras_full, ras_ovf, ras_unf, misalign}, {27'd0, fl});
    endtask

    task automatic run_row(input int idx);
        vec_t r;
        r = vecs[idx];
        PCWre = r.we; PCSrc = r.src; Imm = r.imm; JTarget = r.jt; RegTarget = r.rt; exc_req = r.exc;
        @(negedge CLK);
        check_state(idx, r.pc, r.epc, r.fl);
    endtask

    int n1;

    initial begin
        //            we  src     imm       jt          rt           exc  pc            epc    {e,f,o,u,m}
        vecs.push_back(v(1, 3'b000, 16'h0,    26'h0,      32'h0,       0, 32'h4,        32'h0, 5'b10000));
        vecs.push_back(v(1, 3'b000, 16'h0,    26'h0,      32'h0,       0, 32'h8,        32'h0, 5'b10000));
        vecs.push_back(v(1, 3'b000, 16'h0,    26'h0,      32'h0,       0, 32'hC,        32'h0, 5'b10000));
        vecs.push_back(v(1, 3'b001, 16'hFFFE, 26'h0,      32'h0,       0, 32'h8,        32'h0, 5'b10000));
        vecs.push_back(v(0, 3'b000, 16'h0,    26'h0,      32'h0,       0, 32'h8,        32'h0, 5'b10000));
        vecs.push_back(v(0, 3'b001, 16'h0,    26'h0,      32'h0,       0, 32'h8,        32'h0, 5'b10000));
        vecs.push_back(v(1, 3'b010, 16'h0,    26'h40,     32'h0,       0, 32'h100,      32'h0, 5'b10000));
        vecs.push_back(v(1, 3'b100, 16'h0,    26'h40,     32'h0,       0, 32'h100,      32'h0, 5'b00000));
        vecs.push_back(v(1, 3'b101, 16'h0,    26'h0,      32'h0,       0, 32'h104,      32'h0, 5'b10000));
        vecs.push_back(v(1, 3'b010, 16'h0,    26'h0,      32'h0,       0, 32'h0,        32'h0, 5'b10000));
        // five calls from 0x0..0x400 overflow a four-deep stack
        vecs.push_back(v(1, 3'b100, 16'h0,    26'h40,     32'h0,       0, 32'h100,      32'h0, 5'b00000));
        vecs.push_back(v(1, 3'b100, 16'h0,    26'h80,     32'h0,       0, 32'h200,      32'h0, 5'b00000));
        vecs.push_back(v(1, 3'b100, 16'h0,    26'hC0,     32'h0,       0, 32'h300,      32'h0, 5'b00000));
        vecs.push_back(v(1, 3'b100, 16'h0,    26'h100,    32'h0,       0, 32'h400,      32'h0, 5'b01000));
        vecs.push_back(v(1, 3'b100, 16'h0,    26'h140,    32'h0,       0, 32'h500,      32'h0, 5'b01100));
        vecs.push_back(v(1, 3'b101, 16'h0,    26'h0,      32'h0,       0, 32'h404,      32'h0, 5'b00100));
        vecs.push_back(v(1, 3'b101, 16'h0,    26'h0,      32'h0,       0, 32'h304,      32'h0, 5'b00100));
        vecs.push_back(v(1, 3'b101, 16'h0,    26'h0,      32'h0,       0, 32'h204,      32'h0, 5'b00100));
        vecs.push_back(v(1, 3'b101, 16'h0,    26'h0,      32'h0,       0, 32'h104,      32'h0, 5'b10100));
        vecs.push_back(v(1, 3'b101, 16'h0,    26'h0,      32'h2000,    0, 32'h2000,     32'h0, 5'b10110));
        vecs.push_back(v(1, 3'b010, 16'h0,    26'h8,      32'h0,       0, 32'h20,       32'h0, 5'b10110));
        // exception beats CALL: no push, EPC captures old PC
        vecs.push_back(v(1, 3'b100, 16'h0,    26'h40,     32'h0,       1, 32'h80,       32'h20, 5'b10110));
        vecs.push_back(v(1, 3'b011, 16'h0,    26'h0,      32'h33,      0, 32'h30,       32'h20, 5'b10111));
        vecs.push_back(v(1, 3'b110, 16'h0,    26'h0,      32'h0,       0, 32'h30,       32'h20, 5'b10111));
        vecs.push_back(v(0, 3'b100, 16'h0,    26'h40,     32'h0,       1, 32'h30,       32'h20, 5'b10111));
        vecs.push_back(v(1, 3'b001, 16'h3,    26'h0,      32'h0,       0, 32'h40,       32'h20, 5'b10111));
        n1 = vecs.size();
        // after the mid-cycle reset: wrap-around arithmetic and a lone call
        vecs.push_back(v(1, 3'b001, 16'h8000, 26'h0,      32'h0,       0, 32'hFFFE0004, 32'h0, 5'b10000));
        vecs.push_back(v(1, 3'b010, 16'h0,    26'h3FFFFFF,32'h0,       0, 32'hFFFFFFFC, 32'h0, 5'b10000));
        vecs.push_back(v(1, 3'b000, 16'h0,    26'h0,      32'h0,       0, 32'h0,        32'h0, 5'b10000));
        vecs.push_back(v(1, 3'b100, 16'h0,    26'h10,     32'h0,       0, 32'h40,       32'h0, 5'b00000));
        vecs.push_back(v(1, 3'b111, 16'h0,    26'h0,      32'h0,       0, 32'h40,       32'h0, 5'b00000));
        vecs.push_back(v(1, 3'b101, 16'h0,    26'h0,      32'h0,       0, 32'h4,        32'h0, 5'b10000));

        RST = 1'b1; PCWre = 1'b0; PCSrc = 3'b000; Imm = '0; JTarget = '0; RegTarget = '0; exc_req = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check_state(-1, 32'h0, 32'h0, 5'b10000);

        for (int i = 0; i < n1; i++) run_row(i);

        // asynchronous reset between clock edges while enabled
        PCWre = 1'b1; PCSrc = 3'b000; exc_req = 1'b0;
        #2 RST = 1'b1;
        #1 check_state(-2, 32'h0, 32'h0, 5'b10000);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_state(-3, 32'h4, 32'h0, 5'b10000);
        PCWre = 1'b1; PCSrc = 3'b011; RegTarget = 32'h0;
        @(negedge CLK);
        check_state(-4, 32'h0, 32'h0, 5'b10000);

        for (int i = n1; i < vecs.size(); i++) run_row(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
